debug_bus_arbiter: RTL and testbench
====================================

DEBUG_BUS_ARBITER -- requirements
Module: debug_bus_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, meaning address width in bytes (AWIDTH*8 bits).
REQ-002 SHALL have parameter DWIDTH, default 4, meaning data width in bytes (DWIDTH*8 bits).
REQ-003 SHALL have parameter TIMEOUT, default 1000, meaning max cycles a granted transfer may wait for slave rdy.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have ports m0_wr_en, m0_rd_en, m1_wr_en and m1_rd_en, each input, 1, meaning master write/read request, held until rdy or abort.
REQ-007 SHALL have ports m0_wr_addr, m0_rd_addr, m1_wr_addr and m1_rd_addr, each input, AWIDTH*8, meaning master address.
REQ-008 SHALL have ports m0_wr_data and m1_wr_data, each input, DWIDTH*8, meaning master write data.
REQ-009 SHALL have ports m0_wr_rdy, m0_rd_rdy, m1_wr_rdy and m1_rd_rdy, each output, 1, meaning transfer accepted.
REQ-010 SHALL have ports m0_rd_data and m1_rd_data, each output, DWIDTH*8, meaning read data, a direct copy of s_rd_data.
REQ-011 SHALL have ports s_wr_en and s_rd_en, each output, 1, meaning slave write/read request.
REQ-012 SHALL have ports s_wr_addr and s_rd_addr, each output, AWIDTH*8, meaning slave address.
REQ-013 SHALL have port s_wr_data, output, DWIDTH*8, meaning slave write data.
REQ-014 SHALL have ports s_wr_rdy and s_rd_rdy, each input, 1, meaning slave accepted.
REQ-015 SHALL have port s_rd_data, input, DWIDTH*8, meaning slave read data.
REQ-016 SHALL have port gnt, output, 2, meaning one-hot current owner (bit0=m0, bit1=m1), 0 when none.
REQ-017 SHALL have port err_timeout, output, 1, meaning one-cycle pulse on forced release.

Function
REQ-018 SHALL implement registered FSM states IDLE, WR, RD, GAP; all other state is registered too.
REQ-019 In IDLE, a master is requesting if wr_en|rd_en; with one requester, grant it; with both, grant the master not flagged by the round-robin pointer's last-served bit.
REQ-020 On grant, next state SHALL be WR if granted master's wr_en=1 (write wins over simultaneous read), else RD; gnt and pointer update on the same edge.
REQ-021 Request-to-s_en latency SHALL be exactly 1 cycle (IDLE decision edge, then s_*_en asserted).
REQ-022 In WR: s_wr_en/addr/data SHALL combinationally follow the granted master; granted mX_wr_rdy = s_wr_rdy; all other en/rdy outputs 0.
REQ-023 In RD: s_rd_en/addr SHALL follow the granted master; granted mX_rd_rdy = s_rd_rdy; all other en/rdy outputs 0.
REQ-024 When not driving, s_*_en, s_*_addr and s_wr_data SHALL be 0; non-granted master rdy is always 0.
REQ-025 Completion (s_en & s_rdy in WR/RD) SHALL move to GAP; GAP lasts exactly 1 cycle with no slave request, then IDLE, holding s_rd_data stable for masters sampling one cycle after rdy.
REQ-026 Master abort: granted master drops its en in WR/RD before rdy -> s_en drops the same cycle, FSM goes to GAP, no err_timeout.
REQ-027 A 32-bit wait counter SHALL clear on grant and increment each WR/RD cycle without completion; on reaching TIMEOUT, drop s_en, pulse err_timeout one cycle, go to GAP.
REQ-028 gnt SHALL stay set through WR/RD/GAP and clear on entering IDLE.
REQ-029 Round-robin: after serving mX, a concurrent request from the other master SHALL win next arbitration; no master is starved beyond one transfer.

Reset
REQ-030 On rstn low, asynchronously: FSM=IDLE, gnt=0, pointer=m1 last-served (m0 wins first tie), counter=0, err_timeout=0, all s_* and mX rdy outputs 0; rd_data outputs track s_rd_data.
REQ-031 Reset mid-transfer SHALL drop all requests immediately; no rdy is forwarded after reset.

Verification
REQ-032 m0 write addr 0x10 data 0xDEADBEEF, slave rdy after 3 cycles -> s_wr_en 1 cycle after request, m0_wr_rdy pulses with s_wr_rdy, one GAP cycle, gnt 01 then 00.
REQ-033 m0 and m1 read requested same cycle from reset -> m0 served first, m1 granted after GAP; second tie -> m0 wins again only after m1 served.
REQ-034 m1 asserts wr_en and rd_en together -> write granted first, read granted in a later arbitration.
REQ-035 Slave never responds, TIMEOUT=8 -> s_rd_en high 8 cycles, err_timeout pulses once, FSM IDLE two cycles later.
REQ-036 m0 drops rd_en after 2 cycles while m1 pending -> s_rd_en drops same cycle, no err_timeout, m1 granted after GAP.
REQ-037 rstn asserted during WR with s_wr_rdy high -> s_wr_en and m0_wr_rdy go 0 immediately, gnt=0.

Source files
------------

// File: rtl/debug_bus_arbiter.sv
// Two-master to one-slave debug bus arbiter.
// Round-robin grant, one-cycle gap between transfers, wait-cycle timeout.
module debug_bus_arbiter #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_wr_en,
  input  logic                  m0_rd_en,
  input  logic                  m1_wr_en,
  input  logic                  m1_rd_en,
  input  logic [AWIDTH*8-1:0]   m0_wr_addr,
  input  logic [AWIDTH*8-1:0]   m0_rd_addr,
  input  logic [AWIDTH*8-1:0]   m1_wr_addr,
  input  logic [AWIDTH*8-1:0]   m1_rd_addr,
  input  logic [DWIDTH*8-1:0]   m0_wr_data,
  input  logic [DWIDTH*8-1:0]   m1_wr_data,
  output logic                  m0_wr_rdy,
  output logic                  m0_rd_rdy,
  output logic                  m1_wr_rdy,
  output logic                  m1_rd_rdy,
  output logic [DWIDTH*8-1:0]   m0_rd_data,
  output logic [DWIDTH*8-1:0]   m1_rd_data,
  output logic                  s_wr_en,
  output logic                  s_rd_en,
  output logic [AWIDTH*8-1:0]   s_wr_addr,
  output logic [AWIDTH*8-1:0]   s_rd_addr,
  output logic [DWIDTH*8-1:0]   s_wr_data,
  input  logic                  s_wr_rdy,
  input  logic                  s_rd_rdy,
  input  logic [DWIDTH*8-1:0]   s_rd_data,
  output logic [1:0]            gnt,
  output logic                  err_timeout
);

  localparam int AW = AWIDTH * 8;
  localparam int DW = DWIDTH * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [31:0] cnt_q, cnt_d;

  logic          req0, req1;
  logic          pick1;
  logic          sel1;
  logic          sel_wr_en;
  logic          sel_rd_en;
  logic [AW-1:0] sel_wr_addr;
  logic [AW-1:0] sel_rd_addr;
  logic [DW-1:0] sel_wr_data;
  logic          busy;
  logic          tmo;
  logic          drv_wr;
  logic          drv_rd;
  logic          done;

  assign req0 = m0_wr_en | m0_rd_en;
  assign req1 = m1_wr_en | m1_rd_en;

  // last_q set means m1 was served last, so m0 wins a tie
  assign pick1 = req1 & (~req0 | ~last_q);

  assign sel1        = gnt_q[1];
  assign sel_wr_en   = sel1 ? m1_wr_en   : m0_wr_en;
  assign sel_rd_en   = sel1 ? m1_rd_en   : m0_rd_en;
  assign sel_wr_addr = sel1 ? m1_wr_addr : m0_wr_addr;
  assign sel_rd_addr = sel1 ? m1_rd_addr : m0_rd_addr;
  assign sel_wr_data = sel1 ? m1_wr_data : m0_wr_data;

  assign busy   = (state_q == WR) | (state_q == RD);
  assign tmo    = busy & (cnt_q == 32'(TIMEOUT));
  assign drv_wr = (state_q == WR) & sel_wr_en & ~tmo;
  assign drv_rd = (state_q == RD) & sel_rd_en & ~tmo;
  assign done   = (drv_wr & s_wr_rdy) | (drv_rd & s_rd_rdy);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d  = pick1 ? 2'b10 : 2'b01;
          last_d = pick1;
          cnt_d  = '0;
          if (pick1 ? m1_wr_en : m0_wr_en) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        if (tmo | ~sel_wr_en | done) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RD: begin
        if (tmo | ~sel_rd_en | done) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    s_wr_en   = drv_wr;
    s_rd_en   = drv_rd;
    s_wr_addr = '0;
    s_wr_data = '0;
    s_rd_addr = '0;
    if (drv_wr) begin
      s_wr_addr = sel_wr_addr;
      s_wr_data = sel_wr_data;
    end
    if (drv_rd) begin
      s_rd_addr = sel_rd_addr;
    end
    m0_wr_rdy   = drv_wr & ~sel1 & s_wr_rdy;
    m1_wr_rdy   = drv_wr &  sel1 & s_wr_rdy;
    m0_rd_rdy   = drv_rd & ~sel1 & s_rd_rdy;
    m1_rd_rdy   = drv_rd &  sel1 & s_rd_rdy;
    err_timeout = tmo;
  end

  assign gnt        = gnt_q;
  assign m0_rd_data = s_rd_data;
  assign m1_rd_data = s_rd_data;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Bench for debug_bus_arbiter: directed scenarios plus
// randomized rounds checked against a transfer-schedule model.
module tb_debug_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        m0_wr_en, m0_rd_en, m1_wr_en, m1_rd_en;
  logic [31:0] m0_wr_addr, m0_rd_addr, m1_wr_addr, m1_rd_addr;
  logic [31:0] m0_wr_data, m1_wr_data;
  logic        m0_wr_rdy, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        s_wr_en, s_rd_en;
  logic [31:0] s_wr_addr, s_rd_addr, s_wr_data;
  logic        s_wr_rdy, s_rd_rdy;
  logic [31:0] s_rd_data;
  logic [1:0]  gnt;
  logic        err_timeout;

  int vec  = 0;
  int errs = 0;

  typedef struct {
    int          m;
    bit          wr;
    int          d;
    int          s;
    logic [31:0] rdat;
  } xfer_t;

  always #5 clk = ~clk;

  debug_bus_arbiter #(
    .AWIDTH(4), .DWIDTH(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_wr_en(m0_wr_en), .m0_rd_en(m0_rd_en),
    .m1_wr_en(m1_wr_en), .m1_rd_en(m1_rd_en),
    .m0_wr_addr(m0_wr_addr), .m0_rd_addr(m0_rd_addr),
    .m1_wr_addr(m1_wr_addr), .m1_rd_addr(m1_rd_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_wr_rdy(m0_wr_rdy), .m0_rd_rdy(m0_rd_rdy),
    .m1_wr_rdy(m1_wr_rdy), .m1_rd_rdy(m1_rd_rdy),
    .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
    .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_wr_addr(s_wr_addr), .s_rd_addr(s_rd_addr),
    .s_wr_data(s_wr_data),
    .s_wr_rdy(s_wr_rdy), .s_rd_rdy(s_rd_rdy),
    .s_rd_data(s_rd_data),
    .gnt(gnt), .err_timeout(err_timeout)
  );

  task automatic drive_idle();
    m0_wr_en = 0; m0_rd_en = 0; m1_wr_en = 0; m1_rd_en = 0;
    m0_wr_addr = 0; m0_rd_addr = 0; m1_wr_addr = 0; m1_rd_addr = 0;
    m0_wr_data = 0; m1_wr_data = 0;
    s_wr_rdy = 0; s_rd_rdy = 0; s_rd_data = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rd = $urandom;
    rstn = 1'b0;
    drive_idle();
    m0_wr_en = 1; m1_rd_en = 1; s_wr_rdy = 1; s_rd_rdy = 1;
    m0_wr_addr = 32'h55; s_rd_data = rd;
    #2;
    vec++;
    if ({gnt, s_wr_en, s_rd_en, m0_wr_rdy, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy, err_timeout} !== 9'b0) begin
      errs++;
      $display("FAIL reset_ctrl got=%b exp=0", {gnt, s_wr_en, s_rd_en, m0_wr_rdy, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy, err_timeout});
    end
    vec++;
    if ({s_wr_addr, s_rd_addr, s_wr_data} !== 96'b0) begin
      errs++;
      $display("FAIL reset_bus got=%h exp=0", {s_wr_addr, s_rd_addr, s_wr_data});
    end
    vec++;
    if (m0_rd_data !== rd || m1_rd_data !== rd) begin
      errs++;
      $display("FAIL reset_rdata got=%h/%h exp=%h", m0_rd_data, m1_rd_data, rd);
    end
    @(posedge clk); #1;
    vec++;
    if ({gnt, s_wr_en, s_rd_en} !== 4'b0) begin
      errs++;
      $display("FAIL reset_held got=%b exp=0", {gnt, s_wr_en, s_rd_en});
    end
    drive_idle();
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_write_basic();
    logic       e_en, e_rdy;
    logic [1:0] e_gnt;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      m0_wr_en = (c <= 3);
      m0_wr_addr = 32'h10;
      m0_wr_data = 32'hDEADBEEF;
      s_wr_rdy = (c == 3);
      #1;
      e_en  = (c >= 1 && c <= 3);
      e_rdy = (c == 3);
      e_gnt = (c >= 1 && c <= 4) ? 2'b01 : 2'b00;
      vec++;
      if ({s_wr_en, m0_wr_rdy, gnt} !== {e_en, e_rdy, e_gnt}) begin
        errs++;
        $display("FAIL wr_basic_ctrl c=%0d got en/rdy/gnt=%b exp=%b", c, {s_wr_en, m0_wr_rdy, gnt}, {e_en, e_rdy, e_gnt});
      end
      vec++;
      if (s_wr_addr !== (e_en ? 32'h10 : 32'h0) || s_wr_data !== (e_en ? 32'hDEADBEEF : 32'h0)) begin
        errs++;
        $display("FAIL wr_basic_bus c=%0d got addr=%h data=%h", c, s_wr_addr, s_wr_data);
      end
      vec++;
      if ({s_rd_en, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy, err_timeout} !== 5'b0) begin
        errs++;
        $display("FAIL wr_basic_other c=%0d got=%b exp=0", c, {s_rd_en, m0_rd_rdy, m1_wr_rdy, m1_rd_rdy, err_timeout});
      end
    end
    drive_idle();
  endtask

  task automatic test_timeout();
    logic       e_en, e_err;
    logic [1:0] e_gnt;
    int         pulses;
    pulses = 0;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      m0_rd_en = (c <= 9);
      m0_rd_addr = 32'h44;
      s_rd_rdy = 0;
      #1;
      e_en  = (c >= 1 && c <= TMO);
      e_err = (c == TMO + 1);
      e_gnt = (c >= 1 && c <= TMO + 2) ? 2'b01 : 2'b00;
      if (err_timeout === 1'b1) pulses++;
      vec++;
      if ({s_rd_en, err_timeout, gnt, m0_rd_rdy} !== {e_en, e_err, e_gnt, 1'b0}) begin
        errs++;
        $display("FAIL timeout c=%0d got en/err/gnt/rdy=%b exp=%b", c, {s_rd_en, err_timeout, gnt, m0_rd_rdy}, {e_en, e_err, e_gnt, 1'b0});
      end
    end
    vec++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL timeout_pulses got=%0d exp=1", pulses);
    end
    drive_idle();
  endtask

  task automatic test_abort();
    logic        e_en, e_rdy1;
    logic [31:0] e_addr;
    logic [1:0]  e_gnt;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      m0_rd_en = (c <= 2); m0_rd_addr = 32'hA0;
      m1_rd_en = (c <= 6); m1_rd_addr = 32'hB0;
      s_rd_rdy = (c == 6);
      #1;
      e_en   = (c == 1 || c == 2 || c == 6);
      e_addr = (c == 6) ? 32'hB0 : (e_en ? 32'hA0 : 32'h0);
      e_rdy1 = (c == 6);
      e_gnt  = (c >= 1 && c <= 4) ? 2'b01 :
               (c >= 6 && c <= 7) ? 2'b10 : 2'b00;
      vec++;
      if ({s_rd_en, gnt, m0_rd_rdy, m1_rd_rdy, err_timeout} !== {e_en, e_gnt, 1'b0, e_rdy1, 1'b0}) begin
        errs++;
        $display("FAIL abort c=%0d got en/gnt/r0/r1/err=%b exp=%b", c, {s_rd_en, gnt, m0_rd_rdy, m1_rd_rdy, err_timeout}, {e_en, e_gnt, 1'b0, e_rdy1, 1'b0});
      end
      vec++;
      if (s_rd_addr !== e_addr) begin
        errs++;
        $display("FAIL abort_addr c=%0d got=%h exp=%h", c, s_rd_addr, e_addr);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(posedge clk); #1;
    m0_wr_en = 1; m0_wr_addr = 32'h20; m0_wr_data = 32'h1234;
    @(posedge clk); #1;
    s_wr_rdy = 1;
    #1;
    vec++;
    if ({s_wr_en, m0_wr_rdy, gnt} !== 4'b1101) begin
      errs++;
      $display("FAIL rstmid_pre got=%b exp=1101", {s_wr_en, m0_wr_rdy, gnt});
    end
    rstn = 1'b0;
    #1;
    vec++;
    if ({s_wr_en, m0_wr_rdy, gnt, s_wr_addr} !== 36'b0) begin
      errs++;
      $display("FAIL rstmid_drop got=%h exp=0", {s_wr_en, m0_wr_rdy, gnt, s_wr_addr});
    end
    @(posedge clk); #1;
    vec++;
    if ({s_wr_en, m0_wr_rdy, gnt} !== 4'b0) begin
      errs++;
      $display("FAIL rstmid_held got=%b exp=0", {s_wr_en, m0_wr_rdy, gnt});
    end
    drive_idle();
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic test_random_traffic();
    xfer_t       q[$];
    xfer_t       x;
    bit          last_m1;
    logic [1:0]  pw, pr, bw, br;
    logic [31:0] wa[2], wd[2], ra[2];
    logic [31:0] cur_rd;
    int          fin_w[2], fin_r[2];
    int          s, len, ak, gk, m;
    logic [1:0]  e_gnt;
    logic        e_we, e_re, e_fin;
    logic [3:0]  e_rdy;
    logic [31:0] e_wa, e_wd, e_ra;
    do_reset();
    last_m1 = 1;
    cur_rd = $urandom;
    for (int r = 0; r < 40; r++) begin
      if (r < 2) begin
        pw = 2'b00; pr = 2'b11;
      end else if (r == 2) begin
        pw = 2'b10; pr = 2'b10;
      end else begin
        pw = 2'($urandom); pr = 2'($urandom);
      end
      for (int i = 0; i < 2; i++) begin
        wa[i] = $urandom; wd[i] = $urandom; ra[i] = $urandom;
        fin_w[i] = -1; fin_r[i] = -1;
      end
      q.delete();
      bw = pw; br = pr; s = 1;
      while ((bw | br) != 2'b00) begin
        if ((bw[0] | br[0]) && (bw[1] | br[1])) m = last_m1 ? 0 : 1;
        else m = (bw[1] | br[1]) ? 1 : 0;
        x.m = m; x.wr = bw[m]; x.d = $urandom_range(0, 5);
        x.s = s; x.rdat = $urandom;
        if (bw[m]) begin bw[m] = 0; fin_w[m] = s + x.d; end
        else begin br[m] = 0; fin_r[m] = s + x.d; end
        s = s + x.d + 3;
        last_m1 = (m == 1);
        q.push_back(x);
      end
      len = (q.size() == 0) ? 1 : s - 1;
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        ak = -1; gk = -1;
        foreach (q[k]) begin
          if (c >= q[k].s && c <= q[k].s + q[k].d) ak = k;
          if (c >= q[k].s && c <= q[k].s + q[k].d + 1) gk = k;
        end
        m0_wr_en = pw[0] && c <= fin_w[0]; m0_rd_en = pr[0] && c <= fin_r[0];
        m1_wr_en = pw[1] && c <= fin_w[1]; m1_rd_en = pr[1] && c <= fin_r[1];
        m0_wr_addr = wa[0]; m0_wr_data = wd[0]; m0_rd_addr = ra[0];
        m1_wr_addr = wa[1]; m1_wr_data = wd[1]; m1_rd_addr = ra[1];
        if (ak >= 0) cur_rd = q[ak].rdat;
        s_rd_data = cur_rd;
        e_fin = (ak >= 0) && (c == q[ak].s + q[ak].d);
        if (ak >= 0 && q[ak].wr) s_wr_rdy = e_fin; else s_wr_rdy = 1'($urandom);
        if (ak >= 0 && !q[ak].wr) s_rd_rdy = e_fin; else s_rd_rdy = 1'($urandom);
        #1;
        e_gnt = (gk < 0) ? 2'b00 : (q[gk].m == 1 ? 2'b10 : 2'b01);
        e_we = (ak >= 0) && q[ak].wr;
        e_re = (ak >= 0) && !q[ak].wr;
        e_rdy = 4'b0;
        if (e_fin) e_rdy[q[ak].m * 2 + (q[ak].wr ? 0 : 1)] = 1'b1;
        e_wa = e_we ? wa[q[ak].m] : 32'h0;
        e_wd = e_we ? wd[q[ak].m] : 32'h0;
        e_ra = e_re ? ra[q[ak].m] : 32'h0;
        vec++;
        if ({gnt, s_wr_en, s_rd_en, m1_rd_rdy, m1_wr_rdy, m0_rd_rdy, m0_wr_rdy, err_timeout} !== {e_gnt, e_we, e_re, e_rdy, 1'b0}) begin
          errs++;
          $display("FAIL rand_ctrl r=%0d c=%0d got=%b exp=%b", r, c, {gnt, s_wr_en, s_rd_en, m1_rd_rdy, m1_wr_rdy, m0_rd_rdy, m0_wr_rdy, err_timeout}, {e_gnt, e_we, e_re, e_rdy, 1'b0});
        end
        vec++;
        if ({s_wr_addr, s_wr_data, s_rd_addr} !== {e_wa, e_wd, e_ra}) begin
          errs++;
          $display("FAIL rand_bus r=%0d c=%0d got=%h exp=%h", r, c, {s_wr_addr, s_wr_data, s_rd_addr}, {e_wa, e_wd, e_ra});
        end
        vec++;
        if (m0_rd_data !== cur_rd || m1_rd_data !== cur_rd) begin
          errs++;
          $display("FAIL rand_rdata r=%0d c=%0d got=%h/%h exp=%h", r, c, m0_rd_data, m1_rd_data, cur_rd);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_write_basic();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
